// File: rtl/clk_en_frac.sv
// Fractional-N clock-enable generator: mean period INT + FRAC/2^FRAC_W clk cycles,
// runtime-reprogrammable at tick boundaries, with a secondary enable every SUB_DIV ticks.
module clk_en_frac #(
  parameter int unsigned INT_W    = 8,
  parameter int unsigned FRAC_W   = 16,
  parameter int unsigned DEF_INT  = 50,
  parameter int unsigned DEF_FRAC = 49063,
  parameter int unsigned SUB_DIV  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              sync_clr,
  input  logic [INT_W-1:0]  cfg_int,
  input  logic [FRAC_W-1:0] cfg_frac,
  input  logic              cfg_load,
  output logic              cfg_busy,
  output logic              clk_en_out,
  output logic              sub_en_out
);

  localparam int unsigned SUB_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;

  logic [INT_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [SUB_W-1:0]  sub_cnt_q, sub_cnt_d;
  logic [INT_W-1:0]  int_q, int_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic              pend_q, pend_d;
  logic [INT_W-1:0]  pend_int_q, pend_int_d;
  logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
  logic              en_q, en_d;
  logic              sub_q, sub_d;
  logic [FRAC_W:0]   acc_sum;

  // A zero integer divisor behaves as 1; returns (effective divisor - 1).
  function automatic logic [INT_W-1:0] eff_m1(input logic [INT_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  assign acc_sum = {1'b0, acc_q} + {1'b0, frac_q};

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    sub_cnt_d   = sub_cnt_q;
    int_d       = int_q;
    frac_d      = frac_q;
    pend_d      = pend_q;
    pend_int_d  = pend_int_q;
    pend_frac_d = pend_frac_q;
    en_d        = 1'b0;
    sub_d       = 1'b0;

    if (sync_clr) begin
      cnt_d     = '0;
      acc_d     = '0;
      sub_cnt_d = '0;
      if (pend_q) begin
        int_d  = pend_int_q;
        frac_d = pend_frac_q;
        pend_d = 1'b0;
      end
    end else if (run) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        en_d = 1'b1;
        if (pend_q) begin
          int_d  = pend_int_q;
          frac_d = pend_frac_q;
          acc_d  = '0;
          cnt_d  = eff_m1(pend_int_q);
          pend_d = 1'b0;
        end else begin
          // Accumulator overflow stretches this period by one cycle.
          acc_d = acc_sum[FRAC_W-1:0];
          cnt_d = eff_m1(int_q) + {{(INT_W-1){1'b0}}, acc_sum[FRAC_W]};
        end
        if (sub_cnt_q == '0) begin
          sub_d     = 1'b1;
          sub_cnt_d = SUB_W'(SUB_DIV - 1);
        end else begin
          sub_cnt_d = sub_cnt_q - 1'b1;
        end
      end
    end

    // A load coinciding with an apply stays pending for the next tick.
    if (cfg_load) begin
      pend_d      = 1'b1;
      pend_int_d  = cfg_int;
      pend_frac_d = cfg_frac;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      sub_cnt_q   <= '0;
      int_q       <= INT_W'(DEF_INT);
      frac_q      <= FRAC_W'(DEF_FRAC);
      pend_q      <= 1'b0;
      pend_int_q  <= '0;
      pend_frac_q <= '0;
      en_q        <= 1'b0;
      sub_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sub_cnt_q   <= sub_cnt_d;
      int_q       <= int_d;
      frac_q      <= frac_d;
      pend_q      <= pend_d;
      pend_int_q  <= pend_int_d;
      pend_frac_q <= pend_frac_d;
      en_q        <= en_d;
      sub_q       <= sub_d;
    end
  end

  assign cfg_busy   = pend_q;
  assign clk_en_out = en_q;
  assign sub_en_out = sub_q;

endmodule

// File: tb/tb_clk_en_frac.sv
// Scoreboard bench for clk_en_frac: a tick-level reference model queues the expected
// {clk_en_out, sub_en_out, cfg_busy} per edge; a monitor pops and compares after each edge.
module tb_clk_en_frac;

  localparam int unsigned INT_W    = 8;
  localparam int unsigned FRAC_W   = 16;
  localparam int unsigned DEF_INT  = 50;
  localparam int unsigned DEF_FRAC = 49063;
  localparam int unsigned SUB_DIV  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              run;
  logic              sync_clr;
  logic [INT_W-1:0]  cfg_int;
  logic [FRAC_W-1:0] cfg_frac;
  logic              cfg_load;
  logic              cfg_busy;
  logic              clk_en_out;
  logic              sub_en_out;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  // Reference model: periods from the fractional carry formula, sub pulses by tick count.
  int unsigned     m_int, m_frac, p_int, p_frac, m_wait;
  bit              m_pend;
  longint unsigned m_n;      // accumulations since the phase was zeroed
  longint unsigned m_ticks;  // ticks since the sub phase was zeroed

  clk_en_frac #(
    .INT_W   (INT_W),
    .FRAC_W  (FRAC_W),
    .DEF_INT (DEF_INT),
    .DEF_FRAC(DEF_FRAC),
    .SUB_DIV (SUB_DIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .sync_clr  (sync_clr),
    .cfg_int   (cfg_int),
    .cfg_frac  (cfg_frac),
    .cfg_load  (cfg_load),
    .cfg_busy  (cfg_busy),
    .clk_en_out(clk_en_out),
    .sub_en_out(sub_en_out)
  );

  always #5 clk = ~clk;

  function automatic int unsigned eff(input int unsigned i);
    return (i == 0) ? 1 : i;
  endfunction

  task automatic model_reset();
    m_int = DEF_INT; m_frac = DEF_FRAC; p_int = 0; p_frac = 0;
    m_wait = 0; m_pend = 0; m_n = 0; m_ticks = 0;
  endtask

  task automatic step(input bit r, input bit c, input bit l,
                      input int unsigned ci, input int unsigned cf);
    bit en, sb;
    longint unsigned carry, f;
    @(negedge clk);
    run = r; sync_clr = c; cfg_load = l;
    cfg_int = INT_W'(ci); cfg_frac = FRAC_W'(cf);
    en = 1'b0; sb = 1'b0;
    if (c) begin
      m_wait = 0; m_n = 0; m_ticks = 0;
      if (m_pend) begin m_int = p_int; m_frac = p_frac; m_pend = 0; end
    end else if (r) begin
      if (m_wait == 0) begin
        en = 1'b1;
        sb = (m_ticks % SUB_DIV) == 0;
        m_ticks++;
        if (m_pend) begin
          m_int = p_int; m_frac = p_frac; m_pend = 0; m_n = 0;
          m_wait = eff(m_int) - 1;
        end else begin
          f = longint'(m_frac);
          carry = (((m_n + 1) * f) >> FRAC_W) - ((m_n * f) >> FRAC_W);
          m_n++;
          m_wait = eff(m_int) - 1 + int'(carry);
        end
      end else begin
        m_wait--;
      end
    end
    if (l) begin
      m_pend = 1; p_int = ci % (1 << INT_W); p_frac = cf % (1 << FRAC_W);
    end
    exp_q.push_back({en, sb, m_pend});
  endtask

  task automatic run_n(input int n, input bit r);
    for (int i = 0; i < n; i++) step(r, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin : monitor
    logic [2:0] e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        got = {clk_en_out, sub_en_out, cfg_busy};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL outputs t=%0t en/sub/busy got=%b exp=%b", $time, got, e);
        end
      end
    end
  end

  initial begin : stim
    reset = 1'b1; run = 1'b0; sync_clr = 1'b0; cfg_load = 1'b0;
    cfg_int = '0; cfg_frac = '0;
    #1;
    checks++;
    if ({clk_en_out, sub_en_out, cfg_busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_state got=%b exp=000", {clk_en_out, sub_en_out, cfg_busy});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();

    run_n(3, 1'b1);                                 // first pulse right after reset
    step(1'b1, 1'b0, 1'b1, 4, 0);       run_n(120, 1'b1);
    step(1'b1, 1'b0, 1'b1, 2, 16'h8000); run_n(300, 1'b1);
    step(1'b1, 1'b0, 1'b1, 10, 0);      run_n(33, 1'b1);
    step(1'b1, 1'b0, 1'b1, 3, 0);       run_n(3, 1'b1);
    step(1'b1, 1'b0, 1'b1, 5, 0);       run_n(60, 1'b1);   // last pending load wins
    step(1'b1, 1'b0, 1'b1, 10, 0);      run_n(26, 1'b1);
    run_n(20, 1'b0);                    run_n(30, 1'b1);   // freeze mid-period
    step(1'b1, 1'b1, 1'b0, 0, 0);       run_n(40, 1'b1);   // phase restart
    step(1'b1, 1'b0, 1'b1, 0, 0);       run_n(30, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1, 0);       run_n(30, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1, 16'h1234); run_n(50, 1'b1);
    step(1'b1, 1'b0, 1'b1, 6, 16'h4000);
    step(1'b0, 1'b1, 1'b0, 0, 0);       run_n(40, 1'b1);   // clear applies pending
    step(1'b1, 1'b1, 1'b1, 3, 16'hC000); run_n(40, 1'b1);  // load beside clear apply

    for (int i = 0; i < 4000; i++) begin
      int unsigned ci, cf;
      bit r, c, l;
      r  = $urandom_range(0, 9) != 0;
      c  = $urandom_range(0, 149) == 0;
      l  = $urandom_range(0, 39) == 0;
      ci = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
      cf = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 65535);
      step(r, c, l, ci, cf);
    end

    // Asynchronous reset mid-period with a pending config.
    step(1'b1, 1'b0, 1'b1, 10, 0);
    step(1'b1, 1'b0, 1'b1, 7, 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    run = 1'b0; sync_clr = 1'b0; cfg_load = 1'b0;
    #1;
    checks++;
    if ({clk_en_out, sub_en_out, cfg_busy} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset got=%b exp=000", {clk_en_out, sub_en_out, cfg_busy});
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    run_n(160, 1'b1);                               // default divisor restored

    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
